imm_encoder: RTL



---
 rtl/imm_encoder_pkg.sv | 26 ++
 rtl/imm_encoder_scatter.sv | 50 +++++
 rtl/imm_encoder.sv | 118 +++++++++++
 3 files changed

// File: rtl/imm_encoder_pkg.sv
// Shared immediate-select encodings and immediate-field masks for the RV32I
// immediate generator and its inverse, the immediate encoder.
package imm_encoder_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // Instruction bits occupied by the immediate in each format.
    localparam logic [31:0] MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] MASK_B = 32'hFE00_0F80;
    localparam logic [31:0] MASK_U = 32'hFFFF_F000;
    localparam logic [31:0] MASK_J = 32'hFFFF_F000;

    // True when v[31:lsb] is all zeros or all ones, i.e. v is a sign extension
    // of its low lsb+1 bits.
    function automatic logic upper_all_equal(logic [31:0] v, int unsigned lsb);
        logic [31:0] s;
        s = 32'($signed(v) >>> lsb);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/imm_encoder_scatter.sv
// Combinational scatter of an immediate into the format-specific bit positions
// of a base instruction, with range/alignment and illegal-select flags.
module imm_encoder_scatter
    import imm_encoder_pkg::*;
#(
    parameter int unsigned K = 3
) (
    input  logic [31:0]  imm_i,
    input  logic [K-1:0] imm_sel_i,
    input  logic [31:0]  base_i,
    output logic [31:0]  instr_o,
    output logic         err_range_o,
    output logic         err_sel_o
);

    always_comb begin
        instr_o     = base_i;
        err_range_o = 1'b0;
        err_sel_o   = 1'b0;
        case (imm_sel_i)
            IMM_I: begin
                instr_o     = (base_i & ~MASK_I) | {imm_i[11:0], 20'b0};
                err_range_o = !upper_all_equal(imm_i, 11);
            end
            IMM_S: begin
                instr_o     = (base_i & ~MASK_S) | {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
                err_range_o = !upper_all_equal(imm_i, 11);
            end
            IMM_B: begin
                instr_o     = (base_i & ~MASK_B) |
                              {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
                err_range_o = !upper_all_equal(imm_i, 12) || imm_i[0];
            end
            IMM_U: begin
                instr_o     = (base_i & ~MASK_U) | {imm_i[31:12], 12'b0};
                err_range_o = (imm_i[11:0] != 12'b0);
            end
            IMM_J: begin
                instr_o     = (base_i & ~MASK_J) |
                              {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
                err_range_o = !upper_all_equal(imm_i, 20) || imm_i[0];
            end
            default: begin
                // Illegal select passes the base word through untouched.
                err_sel_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder: S1 registers the request, S2 holds
// the encoded instruction and error flags, plus a saturating error counter.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int unsigned K     = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      imm,
    input  logic [K-1:0]     imm_sel,
    input  logic [31:0]      base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             err_range,
    output logic             err_sel,
    output logic [CNT_W-1:0] err_count
);

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_imm_q, s1_imm_d;
    logic [K-1:0]     s1_sel_q, s1_sel_d;
    logic [31:0]      s1_base_q, s1_base_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      instr_q, instr_d;
    logic             err_range_q, err_range_d;
    logic             err_sel_q, err_sel_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic        ready_s2;
    logic [31:0] sc_instr;
    logic        sc_err_range;
    logic        sc_err_sel;

    imm_encoder_scatter #(
        .K (K)
    ) u_scatter (
        .imm_i       (s1_imm_q),
        .imm_sel_i   (s1_sel_q),
        .base_i      (s1_base_q),
        .instr_o     (sc_instr),
        .err_range_o (sc_err_range),
        .err_sel_o   (sc_err_sel)
    );

    always_comb begin
        ready_s2    = !out_valid_q || out_ready;
        in_ready    = !s1_valid_q || ready_s2;

        s1_valid_d  = s1_valid_q;
        s1_imm_d    = s1_imm_q;
        s1_sel_d    = s1_sel_q;
        s1_base_d   = s1_base_q;
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        err_range_d = err_range_q;
        err_sel_d   = err_sel_q;
        err_count_d = err_count_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_valid && in_ready) begin
            s1_imm_d  = imm;
            s1_sel_d  = imm_sel;
            s1_base_d = base;
        end

        if (ready_s2) begin
            out_valid_d = s1_valid_q;
        end
        if (ready_s2 && s1_valid_q) begin
            instr_d     = sc_instr;
            err_range_d = sc_err_range;
            err_sel_d   = sc_err_sel;
        end

        // Count delivered results carrying any error, saturating at all-ones.
        if (out_valid_q && out_ready && (err_range_q || err_sel_q) && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_imm_q    <= '0;
            s1_sel_q    <= '0;
            s1_base_q   <= '0;
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            err_range_q <= 1'b0;
            err_sel_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_imm_q    <= s1_imm_d;
            s1_sel_q    <= s1_sel_d;
            s1_base_q   <= s1_base_d;
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            err_range_q <= err_range_d;
            err_sel_q   <= err_sel_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign instr     = instr_q;
    assign err_range = err_range_q;
    assign err_sel   = err_sel_q;
    assign err_count = err_count_q;

endmodule
